// File: rtl/load_store_unit.sv
// load_store_unit: requester-side driver for the data memory port.
// Accepts one load/store per transaction, rejects misaligned or illegal-size
// requests, issues a single-cycle MemRead/MemWrite strobe, extends load data
// and returns the result through a valid/ready response handshake.
module load_store_unit #(
    parameter int FAULT_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic                   ReqIsStore,
    input  logic [1:0]             ReqSize,
    input  logic                   ReqUnsigned,
    input  logic [31:0]            ReqAddr,
    input  logic [31:0]            ReqWData,
    output logic                   RespValid,
    input  logic                   RespReady,
    output logic [31:0]            RespData,
    output logic                   RespFault,
    output logic [FAULT_CNT_W-1:0] FaultCount,
    output logic [31:0]            MemAddress,
    output logic [31:0]            MemWriteData,
    output logic                   MemWrite,
    output logic                   MemRead,
    output logic [1:0]             MemByteSel,
    input  logic [31:0]            MemReadData
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    logic        lat_unsigned;
    logic        req_fault;
    logic [31:0] store_data;
    logic [31:0] load_data;

    // Decide whether the request at the port is misaligned or has an illegal size
    always_comb begin
        req_fault = 1'b0;
        case (ReqSize)
            2'b00:   req_fault = (ReqAddr[1:0] != 2'b00);
            2'b11:   req_fault = ReqAddr[0];
            2'b01:   req_fault = 1'b0;
            default: req_fault = 1'b1;
        endcase
    end

    // Mask store data to the access width, zeroing the unused upper bits
    always_comb begin
        store_data = ReqWData;
        case (ReqSize)
            2'b01:   store_data = {24'd0, ReqWData[7:0]};
            2'b11:   store_data = {16'd0, ReqWData[15:0]};
            default: store_data = ReqWData;
        endcase
    end

    // Extend the returned byte/half using the latched size (held on MemByteSel)
    always_comb begin
        load_data = MemReadData;
        case (MemByteSel)
            2'b01: begin
                if (lat_unsigned)
                    load_data = {24'd0, MemReadData[7:0]};
                else
                    load_data = {{24{MemReadData[7]}}, MemReadData[7:0]};
            end
            2'b11: begin
                if (lat_unsigned)
                    load_data = {16'd0, MemReadData[15:0]};
                else
                    load_data = {{16{MemReadData[15]}}, MemReadData[15:0]};
            end
            default: load_data = MemReadData;
        endcase
    end

    assign ReqReady = (state == IDLE);

    // Transaction FSM with all memory-side and response-side outputs registered
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            lat_unsigned <= 1'b0;
            RespValid    <= 1'b0;
            RespData     <= '0;
            RespFault    <= 1'b0;
            FaultCount   <= '0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            MemWrite     <= 1'b0;
            MemRead      <= 1'b0;
            MemByteSel   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        lat_unsigned <= ReqUnsigned;
                        if (req_fault) begin
                            state     <= RESP;
                            RespValid <= 1'b1;
                            RespFault <= 1'b1;
                            RespData  <= '0;
                            if (FaultCount != {FAULT_CNT_W{1'b1}})
                                FaultCount <= FaultCount + 1'b1;
                        end else begin
                            state        <= ACCESS;
                            MemAddress   <= ReqAddr;
                            MemByteSel   <= ReqSize;
                            MemWriteData <= store_data;
                            MemWrite     <= ReqIsStore;
                            MemRead      <= ~ReqIsStore;
                        end
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    MemWrite  <= 1'b0;
                    MemRead   <= 1'b0;
                    RespValid <= 1'b1;
                    RespFault <= 1'b0;
                    RespData  <= MemRead ? load_data : 32'd0;
                end
                RESP: begin
                    if (RespReady) begin
                        state     <= IDLE;
                        RespValid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized transactions against a
// transaction-level reference model (byte array + alignment/extension rules).
// A second instance with a 2-bit fault counter shares the stimulus so the
// saturating counter can be observed.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqIsStore;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespData;
    logic        RespFault;
    logic [15:0] FaultCount;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  MemByteSel;
    logic [31:0] MemReadData;

    logic        sReqReady;
    logic        sRespValid;
    logic [31:0] sRespData;
    logic        sRespFault;
    logic [1:0]  sFaultCount;
    logic [31:0] sMemAddress;
    logic [31:0] sMemWriteData;
    logic        sMemWrite;
    logic        sMemRead;
    logic [1:0]  sMemByteSel;

    logic [7:0]  mem    [0:255];
    logic [7:0]  refMem [0:255];
    logic [31:0] junk;
    logic [7:0]  rdAddr;

    int compared   = 0;
    int mismatched = 0;
    int faultsSeen = 0;

    load_store_unit dut (
        .Clk(Clk), .Rst(Rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqIsStore(ReqIsStore),
        .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .ReqAddr(ReqAddr),
        .ReqWData(ReqWData),
        .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
        .RespFault(RespFault), .FaultCount(FaultCount),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemByteSel(MemByteSel),
        .MemReadData(MemReadData)
    );

    load_store_unit #(.FAULT_CNT_W(2)) dutSmall (
        .Clk(Clk), .Rst(Rst),
        .ReqValid(ReqValid), .ReqReady(sReqReady), .ReqIsStore(ReqIsStore),
        .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .ReqAddr(ReqAddr),
        .ReqWData(ReqWData),
        .RespValid(sRespValid), .RespReady(RespReady), .RespData(sRespData),
        .RespFault(sRespFault), .FaultCount(sFaultCount),
        .MemAddress(sMemAddress), .MemWriteData(sMemWriteData),
        .MemWrite(sMemWrite), .MemRead(sMemRead), .MemByteSel(sMemByteSel),
        .MemReadData(MemReadData)
    );

    always #5 Clk = ~Clk;

    // DataMemory stand-in: combinational right-justified read with junk upper bits
    always_comb begin
        rdAddr = MemAddress[7:0];
        case (MemByteSel)
            2'b01:   MemReadData = {junk[31:8], mem[rdAddr]};
            2'b11:   MemReadData = {junk[31:16], mem[rdAddr + 8'd1], mem[rdAddr]};
            default: MemReadData = {mem[rdAddr + 8'd3], mem[rdAddr + 8'd2],
                                    mem[rdAddr + 8'd1], mem[rdAddr]};
        endcase
    end

    // DataMemory stand-in: byte-lane write on the clock edge when strobed
    always @(posedge Clk) begin
        if (MemWrite) begin
            mem[MemAddress[7:0]] <= MemWriteData[7:0];
            if (MemByteSel != 2'b01)
                mem[MemAddress[7:0] + 8'd1] <= MemWriteData[15:8];
            if (MemByteSel == 2'b00) begin
                mem[MemAddress[7:0] + 8'd2] <= MemWriteData[23:16];
                mem[MemAddress[7:0] + 8'd3] <= MemWriteData[31:24];
            end
        end
    end

    // Fresh don't-care upper read bits every cycle
    always @(negedge Clk) junk <= $urandom;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sizeBytes(input logic [1:0] size);
        return (size == 2'b01) ? 1 : (size == 2'b11) ? 2 : 4;
    endfunction

    function automatic logic [1:0] smallCount();
        return (faultsSeen > 3) ? 2'd3 : 2'(faultsSeen);
    endfunction

    task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data, input int n);
        for (int k = 0; k < n; k++)
            refMem[addr[7:0] + 8'(k)] = 8'((data >> (8 * k)) % 256);
    endtask

    task automatic applyStimulus(input logic isStore, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        logic        expFault;
        logic [31:0] expData;
        logic [31:0] expWData;
        logic [31:0] val;
        int          n;
        n        = sizeBytes(size);
        expFault = (size == 2'b10) || (size == 2'b11 && addr % 2 != 0) ||
                   (size == 2'b00 && addr % 4 != 0);
        expWData = (n == 4) ? wdata : wdata % (32'd1 << (8 * n));
        expData  = 32'd0;
        if (expFault) begin
            faultsSeen++;
        end else if (isStore) begin
            modelWrite(addr, wdata, n);
        end else begin
            val = 32'd0;
            for (int k = 0; k < n; k++)
                val = val + (32'(refMem[addr[7:0] + 8'(k)]) << (8 * k));
            if (n < 4 && !uns && val >= (32'd1 << (8 * n - 1)))
                val = val - (32'd1 << (8 * n));
            expData = val;
        end

        @(negedge Clk);
        ReqValid    = 1'b1;
        ReqIsStore  = isStore;
        ReqSize     = size;
        ReqUnsigned = uns;
        ReqAddr     = addr;
        ReqWData    = wdata;
        checkOutput("req.ready", {sReqReady, ReqReady}, 2'b11);
        @(posedge Clk); #1;
        ReqValid = $urandom_range(0, 1);
        ReqSize  = 2'b10;
        ReqAddr  = $urandom;
        if (!expFault) begin
            checkOutput("strobe", {MemRead, MemWrite}, {~isStore, isStore});
            checkOutput("mem.addr", MemAddress, addr);
            checkOutput("mem.bytesel", MemByteSel, size);
            if (isStore) checkOutput("mem.wdata", MemWriteData, expWData);
            checkOutput("access.resp", {RespValid, ReqReady}, 2'b00);
            checkOutput("small.access", {sMemRead, sMemWrite, sMemByteSel, sMemAddress},
                        {~isStore, isStore, size, addr});
            if (isStore) checkOutput("small.wdata", sMemWriteData, expWData);
            @(posedge Clk); #1;
        end
        checkOutput("no.strobe", {MemRead, MemWrite, sMemRead, sMemWrite}, 4'b0000);
        checkOutput("fault.count", FaultCount, 16'(faultsSeen));
        checkOutput("fault.count.sat", sFaultCount, smallCount());
        for (int c = 0; c <= hold; c++) begin
            RespReady = (c == hold);
            checkOutput("resp.valid", {RespValid, ReqReady}, 2'b10);
            checkOutput("resp.data", RespData, expData);
            checkOutput("resp.fault", RespFault, expFault);
            checkOutput("small.resp", {sRespValid, sRespFault, sRespData}, {1'b1, expFault, expData});
            @(posedge Clk); #1;
        end
        RespReady = 1'b0;
        ReqValid  = 1'b0;
        checkOutput("resp.done", {RespValid, sRespValid}, 2'b00);
        checkOutput("idle.ready", ReqReady, 1'b1);
    endtask

    task automatic resetDuringStore(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge Clk);
        ReqValid = 1'b1; ReqIsStore = 1'b1; ReqSize = 2'b00; ReqUnsigned = 1'b0;
        ReqAddr = addr; ReqWData = wdata;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        checkOutput("rst.strobe.before", MemWrite, 1'b1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        modelWrite(addr, wdata, 4);
        faultsSeen = 0;
        checkOutput("rst.strobe.after", {MemWrite, MemRead}, 2'b00);
        checkOutput("rst.resp", RespValid, 1'b0);
        checkOutput("rst.ready", ReqReady, 1'b1);
        checkOutput("rst.faultcount", FaultCount, 16'd0);
        @(posedge Clk); #1;
        checkOutput("rst.no.second", {MemWrite, MemRead, RespValid}, 3'b000);
    endtask

    initial begin
        int hold;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'($urandom);
            refMem[i] = mem[i];
        end
        Rst = 1'b1; ReqValid = 1'b0; ReqIsStore = 1'b0; ReqSize = 2'b00;
        ReqUnsigned = 1'b0; ReqAddr = '0; ReqWData = '0; RespReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("reset.resp", {RespValid, RespFault, RespData}, 34'd0);
        checkOutput("reset.mem", {MemRead, MemWrite, MemByteSel, MemAddress, MemWriteData}, 68'd0);
        checkOutput("reset.count", FaultCount, 16'd0);
        checkOutput("reset.ready", ReqReady, 1'b1);
        @(negedge Clk);
        Rst = 1'b0;

        applyStimulus(1'b1, 2'b00, 1'b0, 32'd4, 32'hDEADBEEF, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd4, 32'h0, 0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'd33, 32'h123456FF, 0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'd33, 32'h0, 0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'd33, 32'h0, 0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'd26, 32'hFFFF8000, 0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'd26, 32'h0, 0);
        applyStimulus(1'b0, 2'b11, 1'b1, 32'd26, 32'h0, 0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'd24, 32'h1234ABCD, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd6, 32'h0, 0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'd27, 32'h55, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd1, 32'h77, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd4, 32'h0, 3);
        resetDuringStore(32'd8, 32'hCAFEF00D);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd8, 32'h0, 0);

        for (int t = 0; t < 150; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b00) a = a & ~32'd3;
                if (sz == 2'b11) a = a & ~32'd1;
            end
            if ($urandom_range(0, 5) != 0 && sz == 2'b10) sz = 2'b01;
            hold = $urandom_range(0, 3);
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
